// File: rtl/otter_pkg.sv
// Shared PC/fetch types and vectors; no logic.
// Latency and backpressure: not applicable.
package otter_pkg;

   localparam int PC_WIDTH  = 10;
   localparam int CNT_WIDTH = 16;

   typedef logic [PC_WIDTH-1:0] pc_t;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SQUASH,
      HALTED
   } fetch_state_t;

   localparam pc_t RESET_VEC = 10'h000;
   localparam pc_t INTR_VEC  = 10'h3FC;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (interrupt > redirect > accept > hold); purely combinational.
// Latency and backpressure: none, zero-cycle; holding the PC is how a stall is honoured.
module pc_next_sel
   import otter_pkg::*;
#(
   parameter int W = PC_WIDTH
) (
   input  logic         active,
   input  logic         intr_req,
   input  logic         intr_en,
   input  logic         redirect,
   input  logic         accept,
   input  logic [W-1:0] plus,
   input  logic [W-1:0] target,
   input  logic [W-1:0] intr_vec,
   input  logic [W-1:0] count,
   output logic [W-1:0] next_count,
   output logic         take_intr
);

   always_comb begin
      take_intr  = 1'b0;
      next_count = count;
      // the post-reset bubble cycle ignores every control input
      if (active) begin
         take_intr = intr_req & intr_en;
         if (take_intr) begin
            next_count = intr_vec;
         end else if (redirect) begin
            next_count = target;
         end else if (accept) begin
            next_count = plus;
         end
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch-request FSM with interrupt/redirect/halt and a saturating fetch counter.
// Latency 1 cycle PC update; FETCH_ADDR is held stable until accepted, squashed or halted.
module pc_fetch_ctrl #(
   parameter int                  PC_WIDTH  = otter_pkg::PC_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_VEC = otter_pkg::RESET_VEC,
   parameter logic [PC_WIDTH-1:0] INTR_VEC  = otter_pkg::INTR_VEC,
   parameter int                  CNT_WIDTH = otter_pkg::CNT_WIDTH
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [PC_WIDTH-1:0]  PLUS,
   output logic [PC_WIDTH-1:0]  COUNT,
   input  logic                 REDIRECT,
   input  logic [PC_WIDTH-1:0]  TARGET,
   input  logic                 INTR_REQ,
   input  logic                 INTR_EN,
   output logic                 INTR_ACK,
   input  logic                 HALT,
   output logic                 FETCH_VALID,
   input  logic                 FETCH_READY,
   output logic [PC_WIDTH-1:0]  FETCH_ADDR,
   output logic [CNT_WIDTH-1:0] FETCH_CNT
);

   import otter_pkg::fetch_state_t;
   import otter_pkg::IDLE;
   import otter_pkg::FETCH;
   import otter_pkg::SQUASH;
   import otter_pkg::HALTED;

   fetch_state_t          state;
   fetch_state_t          state_nxt;
   logic [PC_WIDTH-1:0]   count_q;
   logic [PC_WIDTH-1:0]   count_nxt;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  fetch_vld;
   logic                  accept;
   logic                  take_intr;

   assign fetch_vld = (state == FETCH);
   assign accept    = fetch_vld & FETCH_READY;

   pc_next_sel #(
      .W (PC_WIDTH)
   ) u_next_sel (
      .active     (state != IDLE),
      .intr_req   (INTR_REQ),
      .intr_en    (INTR_EN),
      .redirect   (REDIRECT),
      .accept     (accept),
      .plus       (PLUS),
      .target     (TARGET),
      .intr_vec   (INTR_VEC),
      .count      (count_q),
      .next_count (count_nxt),
      .take_intr  (take_intr)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            state_nxt = FETCH;
         end
         FETCH: begin
            // an unaccepted request that gets redirected costs exactly one dead cycle
            if (take_intr) begin
               state_nxt = accept ? FETCH : SQUASH;
            end else if (REDIRECT && !accept) begin
               state_nxt = SQUASH;
            end else begin
               state_nxt = HALT ? HALTED : FETCH;
            end
         end
         SQUASH: begin
            if (take_intr || REDIRECT) begin
               state_nxt = SQUASH;
            end else begin
               state_nxt = HALT ? HALTED : FETCH;
            end
         end
         HALTED: begin
            if (take_intr) begin
               state_nxt = FETCH;
            end else begin
               state_nxt = HALT ? HALTED : FETCH;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= IDLE;
         count_q <= RESET_VEC;
         cnt_q   <= '0;
      end else begin
         state   <= state_nxt;
         count_q <= count_nxt;
         if (accept && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign COUNT       = count_q;
   assign FETCH_ADDR  = count_q;
   assign FETCH_VALID = fetch_vld;
   assign FETCH_CNT   = cnt_q;
   assign INTR_ACK    = take_intr;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed plan plus random traffic against a flag-based model.
module tb_pc_fetch_ctrl;
   import otter_pkg::*;

   logic        CLK;
   logic        RST_N;
   pc_t         PLUS;
   pc_t         COUNT;
   logic        REDIRECT;
   pc_t         TARGET;
   logic        INTR_REQ;
   logic        INTR_EN;
   logic        INTR_ACK;
   logic        HALT;
   logic        FETCH_VALID;
   logic        FETCH_READY;
   pc_t         FETCH_ADDR;
   logic [15:0] FETCH_CNT;

   int total = 0;
   int bad   = 0;

   // model: bubble after reset, squash pending, halted; fetching otherwise
   pc_t         m_pc, n_pc;
   logic [15:0] m_cnt, n_cnt;
   logic        m_bubble, n_bubble;
   logic        m_squash, n_squash;
   logic        m_halted, n_halted;
   logic        m_vld, m_ack, m_acc;

   logic        plus_bad;
   pc_t         plus_rand;

   assign PLUS = plus_bad ? plus_rand : pc_t'(m_pc + 10'd1);

   pc_fetch_ctrl dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .PLUS        (PLUS),
      .COUNT       (COUNT),
      .REDIRECT    (REDIRECT),
      .TARGET      (TARGET),
      .INTR_REQ    (INTR_REQ),
      .INTR_EN     (INTR_EN),
      .INTR_ACK    (INTR_ACK),
      .HALT        (HALT),
      .FETCH_VALID (FETCH_VALID),
      .FETCH_READY (FETCH_READY),
      .FETCH_ADDR  (FETCH_ADDR),
      .FETCH_CNT   (FETCH_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always_comb begin
      m_vld    = !m_bubble && !m_squash && !m_halted;
      m_ack    = !m_bubble && INTR_REQ && INTR_EN;
      m_acc    = m_vld && FETCH_READY;
      n_pc     = m_pc;
      n_cnt    = m_cnt;
      n_bubble = 1'b0;
      n_squash = m_squash;
      n_halted = m_halted;
      if (!m_bubble) begin
         if (m_ack)         n_pc = INTR_VEC;
         else if (REDIRECT) n_pc = TARGET;
         else if (m_acc)    n_pc = PLUS;
         if (m_acc && m_cnt != 16'hFFFF) n_cnt = m_cnt + 16'd1;
         if (m_halted) begin
            n_halted = !m_ack && HALT;
         end else if (m_squash) begin
            n_squash = m_ack || REDIRECT;
            n_halted = !n_squash && HALT;
         end else if (m_ack || REDIRECT) begin
            n_squash = !m_acc;
            n_halted = !m_ack && m_acc && HALT;
         end else begin
            n_halted = HALT;
         end
      end
   end

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_pc     <= RESET_VEC;
         m_cnt    <= '0;
         m_bubble <= 1'b1;
         m_squash <= 1'b0;
         m_halted <= 1'b0;
      end else begin
         m_pc     <= n_pc;
         m_cnt    <= n_cnt;
         m_bubble <= n_bubble;
         m_squash <= n_squash;
         m_halted <= n_halted;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
      end
   endtask

   // per-cycle model comparison at the falling edge, then advance past the next rising edge
   task automatic tick();
      @(negedge CLK);
      chk("m_count", 32'(COUNT), 32'(m_pc));
      chk("m_addr",  32'(FETCH_ADDR), 32'(m_pc));
      chk("m_valid", 32'(FETCH_VALID), 32'(m_vld));
      chk("m_cnt",   32'(FETCH_CNT), 32'(m_cnt));
      chk("m_ack",   32'(INTR_ACK), 32'(m_ack));
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_ctl();
      REDIRECT = 1'b0;
      INTR_REQ = 1'b0;
      INTR_EN  = 1'b0;
      HALT     = 1'b0;
   endtask

   initial begin
      int guard;
      RST_N       = 1'b0;
      TARGET      = '0;
      FETCH_READY = 1'b1;
      plus_bad    = 1'b0;
      plus_rand   = '0;
      clear_ctl();
      #2;
      chk("rst_count", 32'(COUNT), 32'h000);
      chk("rst_valid", 32'(FETCH_VALID), 32'd0);
      chk("rst_cnt",   32'(FETCH_CNT), 32'd0);
      chk("rst_ack",   32'(INTR_ACK), 32'd0);
      #15;
      RST_N = 1'b1;
      chk("idle_valid", 32'(FETCH_VALID), 32'd0);
      tick();
      chk("first_valid", 32'(FETCH_VALID), 32'd1);
      chk("first_addr",  32'(FETCH_ADDR), 32'h000);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("seq_addr", 32'(FETCH_ADDR), 32'(i));
         chk("seq_cnt",  32'(FETCH_CNT), 32'(i));
      end

      FETCH_READY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_addr", 32'(FETCH_ADDR), 32'h005);
         chk("stall_cnt",  32'(FETCH_CNT), 32'd5);
      end
      FETCH_READY = 1'b1;
      tick();
      chk("resume_count", 32'(COUNT), 32'h006);
      chk("resume_cnt",   32'(FETCH_CNT), 32'd6);
      FETCH_READY = 1'b0;

      REDIRECT = 1'b1;
      TARGET   = 10'h120;
      tick();
      chk("redir_count", 32'(COUNT), 32'h120);
      chk("squash_valid", 32'(FETCH_VALID), 32'd0);
      clear_ctl();
      tick();
      chk("redir_valid", 32'(FETCH_VALID), 32'd1);
      chk("redir_addr",  32'(FETCH_ADDR), 32'h120);

      INTR_REQ = 1'b1;
      INTR_EN  = 1'b1;
      REDIRECT = 1'b1;
      TARGET   = 10'h055;
      #1;
      chk("intr_ack_hi", 32'(INTR_ACK), 32'd1);
      tick();
      chk("intr_count", 32'(COUNT), 32'h3FC);
      clear_ctl();
      #1;
      chk("intr_ack_lo", 32'(INTR_ACK), 32'd0);
      tick();
      chk("intr_refetch", 32'(FETCH_ADDR), 32'h3FC);

      INTR_REQ = 1'b1;
      REDIRECT = 1'b1;
      TARGET   = 10'h0AA;
      #1;
      chk("intr_dis_ack", 32'(INTR_ACK), 32'd0);
      tick();
      chk("intr_dis_count", 32'(COUNT), 32'h0AA);
      clear_ctl();
      tick();

      REDIRECT = 1'b1;
      TARGET   = 10'h3FF;
      tick();
      clear_ctl();
      tick();
      chk("wrap_pre_addr", 32'(FETCH_ADDR), 32'h3FF);
      FETCH_READY = 1'b1;
      HALT        = 1'b1;
      tick();
      chk("wrap_count",   32'(COUNT), 32'h000);
      chk("halt_valid",   32'(FETCH_VALID), 32'd0);
      chk("wrap_cnt",     32'(FETCH_CNT), 32'd7);
      tick();
      chk("halt_hold_valid", 32'(FETCH_VALID), 32'd0);
      INTR_REQ = 1'b1;
      INTR_EN  = 1'b1;
      #1;
      chk("wake_ack", 32'(INTR_ACK), 32'd1);
      tick();
      chk("wake_count", 32'(COUNT), 32'h3FC);
      chk("wake_valid", 32'(FETCH_VALID), 32'd1);
      clear_ctl();
      FETCH_READY = 1'b0;
      tick();
      #3;
      RST_N = 1'b0;
      #1;
      chk("arst_count", 32'(COUNT), 32'h000);
      chk("arst_valid", 32'(FETCH_VALID), 32'd0);
      chk("arst_cnt",   32'(FETCH_CNT), 32'd0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         tick();
         RST_N       = ($urandom_range(0, 999) != 0);
         FETCH_READY = ($urandom_range(0, 9) < 7);
         REDIRECT    = ($urandom_range(0, 9) == 0);
         TARGET      = pc_t'($urandom);
         INTR_REQ    = ($urandom_range(0, 19) == 0);
         INTR_EN     = 1'($urandom_range(0, 1));
         HALT        = ($urandom_range(0, 7) == 0);
         plus_bad    = ($urandom_range(0, 9) == 0);
         plus_rand   = pc_t'($urandom);
      end

      clear_ctl();
      plus_bad    = 1'b0;
      FETCH_READY = 1'b1;
      RST_N       = 1'b0;
      #2;
      RST_N = 1'b1;
      guard = 0;
      while (m_cnt != 16'hFFFE && guard < 70000) begin
         tick();
         guard++;
      end
      chk("sat_pre", 32'(FETCH_CNT), 32'hFFFE);
      tick();
      chk("sat_max", 32'(FETCH_CNT), 32'hFFFF);
      tick();
      chk("sat_hold", 32'(FETCH_CNT), 32'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter register and fetch-request controller. Holds the current PC (COUNT), drives it to the incrementer (PCp1) and the instruction memory, and loads the next PC from the incrementer result (PLUS), a redirect target, or the interrupt vector. Fetches use a valid/ready handshake with instruction memory. Supports halt, squash-on-redirect and a saturating fetch counter.

Parameters:
PC_WIDTH, 10, width of COUNT/PLUS/TARGET/FETCH_ADDR
RESET_VEC, 10'h000, COUNT value on reset
INTR_VEC, 10'h3FC, COUNT value loaded when an interrupt is taken
CNT_WIDTH, 16, width of FETCH_CNT

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
PLUS  in  PC_WIDTH  COUNT+1 from the incrementer stage
COUNT  out  PC_WIDTH  current PC, to the incrementer and debug
REDIRECT  in  1  load TARGET (jump/branch taken)
TARGET  in  PC_WIDTH  redirect destination
INTR_REQ  in  1  interrupt request, level
INTR_EN  in  1  interrupt enable
INTR_ACK  out  1  one-cycle pulse when the interrupt is taken
HALT  in  1  stop issuing fetches while high
FETCH_VALID  out  1  fetch request valid
FETCH_READY  in  1  instruction memory accepts request
FETCH_ADDR  out  PC_WIDTH  equals COUNT
FETCH_CNT  out  CNT_WIDTH  accepted fetches, saturating

Behaviour:
- Reset (RST_N low, asynchronous):
  - COUNT=RESET_VEC
  - state=IDLE
  - FETCH_VALID=0, INTR_ACK=0, FETCH_CNT=0
  - RST_N is sampled through no synchronizer inside this block.
- States: IDLE, FETCH, SQUASH, HALTED. FETCH_VALID=1 only in FETCH. FETCH_ADDR is always COUNT.
- IDLE: one bubble cycle after reset release. Goes to FETCH unconditionally; HALT, REDIRECT and INTR are ignored.
- Next-PC priority, evaluated each cycle in FETCH/SQUASH/HALTED:
  1. take_intr = INTR_REQ & INTR_EN
  2. REDIRECT
  3. accept = FETCH_VALID & FETCH_READY
  4. otherwise hold
- take_intr:
  - COUNT<=INTR_VEC, INTR_ACK=1 (combinational in that cycle, registered nowhere else).
  - Next state SQUASH if the current request was not accepted, else FETCH.
  - From HALTED: always go to FETCH. The interrupt wakes the block.
- REDIRECT (no interrupt): COUNT<=TARGET.
  - FETCH with no accept: go to SQUASH. The unaccepted request is abandoned; FETCH_VALID is low for exactly one cycle.
  - FETCH with accept: go to FETCH, or HALTED if HALT=1.
  - HALTED: COUNT updates; stay HALTED while HALT=1.
- accept only: COUNT<=PLUS; FETCH_CNT<=FETCH_CNT+1, saturating at all-ones. If HALT=1, go to HALTED, else stay in FETCH.
- Hold (FETCH, no accept, no redirect, no intr):
  - COUNT and FETCH_ADDR stay stable. The valid/ready rule is that the address is unchanged until accepted or squashed.
  - HALT=1 here goes to HALTED, dropping the request.
- SQUASH: goes to FETCH, or HALTED if HALT=1. A redirect or interrupt in SQUASH updates COUNT and stays in SQUASH for one more cycle.
- HALTED: leaves to FETCH when HALT=0 (re-fetches COUNT). HALT is ignored in IDLE.
- Wrap-around: COUNT=10'h3FF accepted gives COUNT=10'h000 via PLUS. The block performs no arithmetic on the PC.
- FETCH_CNT increments only on accept, including the accept cycle of a simultaneous redirect/interrupt.
- Reset mid-operation: all state returns to reset values immediately; no pending request survives.

Decomposition:
- Shared package (otter_pkg):
  - typedef pc_t = logic [PC_WIDTH-1:0]
  - enum fetch_state_t {IDLE, FETCH, SQUASH, HALTED}
  - constants RESET_VEC and INTR_VEC
- One natural sub-module: pc_next_sel. Combinational priority mux producing next COUNT and take_intr from PLUS/TARGET/INTR_VEC and the control inputs.
- FSM, COUNT register and FETCH_CNT stay in pc_fetch_ctrl.

Test Plan:
1. Reset release with FETCH_READY=1, PLUS=COUNT+1: cycle 1 FETCH_VALID=0 (IDLE). Then addresses 0x000,0x001,0x002…, and FETCH_CNT counts each.
2. FETCH_READY=0 for 3 cycles at COUNT=0x005: FETCH_ADDR stays 0x005 and FETCH_CNT is unchanged. When READY rises, COUNT=0x006.
3. REDIRECT=1, TARGET=0x120 while READY=0: next cycle COUNT=0x120 and FETCH_VALID=0 (SQUASH). The following cycle FETCH_VALID=1, FETCH_ADDR=0x120.
4. INTR_REQ=1, INTR_EN=1 together with REDIRECT, and a separate case with INTR_EN=0:
   - enabled: COUNT=0x3FC and a single-cycle INTR_ACK.
   - disabled: COUNT=TARGET and INTR_ACK=0.
5. HALT=1 at an accepted fetch of 0x3FF: COUNT=0x000, then FETCH_VALID=0 while halted. INTR_REQ/EN during HALTED gives COUNT=0x3FC and FETCH resumes. RST_N low mid-stall gives COUNT=0x000 asynchronously, FETCH_VALID=0 and FETCH_CNT=0.
6. Force FETCH_CNT to 0xFFFE with continuous accepts: it reaches 0xFFFF and stays there.
